// File: rtl/alu_result_checker.sv
// Result-side monitor for the ALU: snoops each issued operation, ages an expected
// response through a LATENCY-deep pipeline and scores it against the ALU outputs.
module alu_result_checker #(
  parameter int N       = 8,
  parameter int LATENCY = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           clr_i,
  input  logic [N-1:0]   opa_i,
  input  logic [N-1:0]   opb_i,
  input  logic           cin_i,
  input  logic           ce_i,
  input  logic           mode_i,
  input  logic [3:0]     cmd_i,
  input  logic [1:0]     valid_i,
  input  logic [2*N-1:0] res_i,
  input  logic           err_i,
  input  logic           oflow_i,
  input  logic           cout_i,
  input  logic           g_i,
  input  logic           l_i,
  input  logic           e_i,
  output logic           chk_valid_o,
  output logic           mismatch_o,
  output logic           sticky_fail_o,
  output logic [15:0]    pass_cnt_o,
  output logic [15:0]    fail_cnt_o,
  output logic [15:0]    skip_cnt_o,
  output logic [3:0]     fail_cmd_o,
  output logic [2*N-1:0] fail_exp_o,
  output logic [2*N-1:0] fail_act_o
);
  localparam int W2 = 2 * N;
  localparam logic [N:0]   ONE_X = 1;
  localparam logic [N-1:0] ONE_N = 1;

  typedef struct packed {
    logic [3:0]    cmd;
    logic [W2-1:0] res;
    logic          err, oflow, cout, g, l, e;
    logic          m_cout, m_ofl, m_cmp;
  } entry_t;

  function automatic logic [W2-1:0] zx1(input logic [N:0] v);
    return {{(N-1){1'b0}}, v};
  endfunction

  function automatic logic [W2-1:0] zxn(input logic [N-1:0] v);
    return {{N{1'b0}}, v};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  entry_t        exp_d;
  logic          ops_ok;
  logic [N:0]    a_x, b_x, cin_x, sum_ab, sum_abc, inc_a, inc_b, b_cin;
  logic [N-1:0]  a_sh, cin_n;
  logic [W2-1:0] mul_inc, shl_mul;

  always_comb begin
    a_x     = {1'b0, opa_i};
    b_x     = {1'b0, opb_i};
    cin_x   = {{N{1'b0}}, cin_i};
    cin_n   = {{(N-1){1'b0}}, cin_i};
    sum_ab  = a_x + b_x;
    sum_abc = sum_ab + cin_x;
    b_cin   = b_x + cin_x;
    inc_a   = a_x + ONE_X;
    inc_b   = b_x + ONE_X;
    a_sh    = {opa_i[N-2:0], 1'b0};
    mul_inc = zx1(inc_a) * zx1(inc_b);
    shl_mul = zxn(a_sh) * zxn(opb_i);
    exp_d     = '0;
    exp_d.cmd = cmd_i;
    ops_ok    = 1'b0;
    case (cmd_i)
      4'h0: begin ops_ok = &valid_i; exp_d.res = zx1(sum_ab);  exp_d.cout = sum_ab[N];  exp_d.m_cout = 1'b1; end
      4'h1: begin ops_ok = &valid_i; exp_d.res = zxn(opa_i - opb_i); exp_d.oflow = a_x < b_x; exp_d.m_ofl = 1'b1; end
      4'h2: begin ops_ok = &valid_i; exp_d.res = zx1(sum_abc); exp_d.cout = sum_abc[N]; exp_d.m_cout = 1'b1; end
      4'h3: begin ops_ok = &valid_i; exp_d.res = zxn(opa_i - opb_i - cin_n); exp_d.oflow = a_x < b_cin; exp_d.m_ofl = 1'b1; end
      4'h4: begin ops_ok = valid_i[0]; exp_d.res = zx1(inc_a); exp_d.cout = inc_a[N]; exp_d.m_cout = 1'b1; end
      4'h5: begin ops_ok = valid_i[0]; exp_d.res = zxn(opa_i - ONE_N); exp_d.oflow = (opa_i == '0); exp_d.m_ofl = 1'b1; end
      4'h6: begin ops_ok = valid_i[1]; exp_d.res = zx1(inc_b); exp_d.cout = inc_b[N]; exp_d.m_cout = 1'b1; end
      4'h7: begin ops_ok = valid_i[1]; exp_d.res = zxn(opb_i - ONE_N); exp_d.oflow = (opb_i == '0); exp_d.m_ofl = 1'b1; end
      4'h8: begin
        ops_ok = &valid_i;
        exp_d.g = opa_i > opb_i; exp_d.l = opa_i < opb_i; exp_d.e = opa_i == opb_i;
        exp_d.m_cmp = 1'b1;
      end
      4'h9: begin ops_ok = &valid_i; exp_d.res = mul_inc; end
      4'hA: begin ops_ok = &valid_i; exp_d.res = shl_mul; end
      default: ops_ok = 1'b0;
    endcase
    // Error responses compare only RES and ERR, so all flag masks drop.
    if (!ops_ok) begin
      exp_d     = '0;
      exp_d.cmd = cmd_i;
      exp_d.err = 1'b1;
    end
  end

  logic   [LATENCY-1:0] vld_q;
  entry_t [LATENCY-1:0] ent_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      ent_q <= '0;
    end else begin
      vld_q[0] <= ce_i & mode_i;
      ent_q[0] <= exp_d;
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        ent_q[i] <= ent_q[i-1];
      end
    end
  end

  entry_t ret;
  logic   ret_vld, mis;

  always_comb begin
    ret     = ent_q[LATENCY-1];
    ret_vld = vld_q[LATENCY-1];
    mis = (res_i != ret.res) | (err_i != ret.err)
        | (ret.m_cout & (cout_i != ret.cout))
        | (ret.m_ofl & (oflow_i != ret.oflow))
        | (ret.m_cmp & ({g_i, l_i, e_i} != {ret.g, ret.l, ret.e}));
  end

  logic          chk_valid_q, mismatch_q, sticky_q, sticky_d;
  logic [15:0]   pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
  logic [3:0]    fcmd_q, fcmd_d;
  logic [W2-1:0] fexp_q, fexp_d, fact_q, fact_d;

  always_comb begin
    pass_d   = pass_q;
    fail_d   = fail_q;
    skip_d   = skip_q;
    sticky_d = sticky_q;
    fcmd_d   = fcmd_q;
    fexp_d   = fexp_q;
    fact_d   = fact_q;
    if (clr_i) begin
      pass_d = '0; fail_d = '0; skip_d = '0;
      sticky_d = 1'b0; fcmd_d = '0; fexp_d = '0; fact_d = '0;
    end else begin
      if (ce_i && !mode_i) skip_d = sat_inc(skip_q);
      if (ret_vld && mis) begin
        fail_d = sat_inc(fail_q);
        if (!sticky_q) begin
          sticky_d = 1'b1;
          fcmd_d   = ret.cmd;
          fexp_d   = ret.res;
          fact_d   = res_i;
        end
      end else if (ret_vld) begin
        pass_d = sat_inc(pass_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chk_valid_q <= 1'b0; mismatch_q <= 1'b0; sticky_q <= 1'b0;
      pass_q <= '0; fail_q <= '0; skip_q <= '0;
      fcmd_q <= '0; fexp_q <= '0; fact_q <= '0;
    end else begin
      chk_valid_q <= ret_vld;
      mismatch_q  <= ret_vld & mis;
      sticky_q    <= sticky_d;
      pass_q <= pass_d; fail_q <= fail_d; skip_q <= skip_d;
      fcmd_q <= fcmd_d; fexp_q <= fexp_d; fact_q <= fact_d;
    end
  end

  assign chk_valid_o   = chk_valid_q;
  assign mismatch_o    = mismatch_q;
  assign sticky_fail_o = sticky_q;
  assign pass_cnt_o    = pass_q;
  assign fail_cnt_o    = fail_q;
  assign skip_cnt_o    = skip_q;
  assign fail_cmd_o    = fcmd_q;
  assign fail_exp_o    = fexp_q;
  assign fail_act_o    = fact_q;
endmodule

// File: tb/tb_alu_result_checker.sv
// Scoreboard bench: directed ALU ops with hand-computed responses; a monitor pops
// expected CHK_VALID cycle and MISMATCH per pulse of the LATENCY=1 checker.
module tb_alu_result_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, rst3_n = 1'b0, clr = 1'b0;
  logic        ce1 = 1'b0, ce3 = 1'b0, mode = 1'b0, cin = 1'b0;
  logic [7:0]  opa = '0, opb = '0;
  logic [3:0]  cmd = '0;
  logic [1:0]  valid = '0;
  logic [15:0] res1 = '0, res3 = 16'd8;
  logic        err1 = 0, oflow1 = 0, cout1 = 0, g1 = 0, l1 = 0, e1 = 0;
  logic        zf = 1'b0;

  logic        cv1, mis1, st1, cv3, mis3, st3;
  logic [15:0] pc1, fc1, sc1, pc3, fc3, sc3, fexp1, fact1, fexp3, fact3;
  logic [3:0]  fcmd1, fcmd3;

  alu_result_checker #(.N(8), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .opa_i(opa), .opb_i(opb), .cin_i(cin),
    .ce_i(ce1), .mode_i(mode), .cmd_i(cmd), .valid_i(valid), .res_i(res1),
    .err_i(err1), .oflow_i(oflow1), .cout_i(cout1), .g_i(g1), .l_i(l1), .e_i(e1),
    .chk_valid_o(cv1), .mismatch_o(mis1), .sticky_fail_o(st1), .pass_cnt_o(pc1),
    .fail_cnt_o(fc1), .skip_cnt_o(sc1), .fail_cmd_o(fcmd1), .fail_exp_o(fexp1), .fail_act_o(fact1));

  alu_result_checker #(.N(8), .LATENCY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst3_n), .clr_i(clr), .opa_i(opa), .opb_i(opb), .cin_i(cin),
    .ce_i(ce3), .mode_i(mode), .cmd_i(cmd), .valid_i(valid), .res_i(res3),
    .err_i(zf), .oflow_i(zf), .cout_i(zf), .g_i(zf), .l_i(zf), .e_i(zf),
    .chk_valid_o(cv3), .mismatch_o(mis3), .sticky_fail_o(st3), .pass_cnt_o(pc3),
    .fail_cnt_o(fc3), .skip_cnt_o(sc3), .fail_cmd_o(fcmd3), .fail_exp_o(fexp3), .fail_act_o(fact3));

  typedef struct { logic mis; int cyc; } exp_t;
  exp_t sbq[$];

  int ncmp = 0, nfail = 0, cyc = 0, n_cv3 = 0, last_cv3 = 0;
  logic [15:0] pend_res = '0;
  logic [5:0]  pend_fl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor for the LATENCY=1 checker: every pulse must match the head of the queue.
  always @(posedge clk) begin
    #1;
    if (cv1 === 1'b1) begin
      if (sbq.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL unexpected_chk_valid: got pulse expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("chk_valid_cycle", cyc, e.cyc);
        chk("mismatch", {31'd0, mis1}, {31'd0, e.mis});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cv3 === 1'b1) begin
      n_cv3++;
      last_cv3 = cyc;
    end
  end

  // One negedge per call: presents the previous op's ALU response, issues this op.
  // fl = {err, oflow, cout, g, l, e}
  task automatic op(input logic c_e, input logic md, input logic [3:0] c, input logic [1:0] v,
                    input logic [7:0] a, input logic [7:0] b, input logic ci,
                    input logic [15:0] r, input logic [5:0] fl, input logic em);
    @(negedge clk);
    res1 = pend_res;
    {err1, oflow1, cout1, g1, l1, e1} = pend_fl;
    ce1 = c_e; mode = md; cmd = c; valid = v; opa = a; opb = b; cin = ci;
    pend_res = r; pend_fl = fl;
    if (c_e && md) sbq.push_back('{em, cyc + 2});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b1, 4'h0, 2'b00, 8'd0, 8'd0, 1'b0, 16'h5A5A, 6'h3F, 1'b0);
  endtask

  task automatic clear();
    @(negedge clk);
    clr = 1'b1; ce1 = 1'b0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  int c0;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_chk_valid", cv1, 0); chk("rst_mismatch", mis1, 0); chk("rst_sticky", st1, 0);
    chk("rst_pass", pc1, 0); chk("rst_fail", fc1, 0); chk("rst_skip", sc1, 0);
    chk("rst_fcmd", fcmd1, 0); chk("rst_fexp", fexp1, 0); chk("rst_fact", fact1, 0);
    rst_n = 1'b1; rst3_n = 1'b1;

    // INC_A 255 -> 256, carry out
    op(1, 1, 4'h4, 2'b01, 8'd255, 8'd0, 0, 16'd256, 6'b001000, 0);
    idle(3);
    chk("t1_pass", pc1, 1); chk("t1_fail", fc1, 0);

    // DEC_A underflow then INC_B with missing VALID[1], back to back
    clear();
    op(1, 1, 4'h5, 2'b01, 8'd0, 8'd0, 0, 16'd255, 6'b010000, 0);
    op(1, 1, 4'h6, 2'b01, 8'd0, 8'd9, 0, 16'd0, 6'b100000, 0);
    idle(3);
    chk("t2_pass", pc1, 2); chk("t2_fail", fc1, 0);

    // MUL_INC 65*64=4160 with ALU reporting 4159
    op(1, 1, 4'h9, 2'b11, 8'd64, 8'd63, 0, 16'd4159, 6'b000000, 1);
    idle(3);
    chk("t3_sticky", st1, 1); chk("t3_fcmd", fcmd1, 9);
    chk("t3_fexp", fexp1, 4160); chk("t3_fact", fact1, 4159); chk("t3_fail", fc1, 1);
    op(1, 1, 4'h0, 2'b11, 8'd1, 8'd1, 0, 16'd3, 6'b000000, 1);
    idle(3);
    chk("t3b_fail", fc1, 2); chk("t3b_fcmd", fcmd1, 9);
    chk("t3b_fexp", fexp1, 4160); chk("t3b_fact", fact1, 4159); chk("t3b_pass", pc1, 2);

    // Remaining commands, masked-flag and flag-mismatch cases, back to back
    op(1, 1, 4'hA, 2'b11, 8'd200, 8'd3, 0, 16'd432, 6'b000000, 0);
    op(1, 1, 4'h8, 2'b11, 8'd5, 8'd9, 0, 16'd0, 6'b000010, 0);
    op(1, 1, 4'h3, 2'b11, 8'd5, 8'd5, 1, 16'd255, 6'b010000, 0);
    op(1, 1, 4'h2, 2'b11, 8'd200, 8'd55, 1, 16'd256, 6'b001000, 0);
    op(1, 1, 4'hC, 2'b11, 8'd1, 8'd2, 0, 16'd0, 6'b100000, 0);
    op(1, 1, 4'h1, 2'b11, 8'd9, 8'd4, 0, 16'd5, 6'b001000, 0);
    op(1, 1, 4'h8, 2'b11, 8'd5, 8'd9, 0, 16'd0, 6'b000100, 1);
    op(1, 1, 4'h0, 2'b01, 8'd1, 8'd1, 0, 16'd0, 6'b000000, 1);
    idle(3);
    chk("t3c_pass", pc1, 8); chk("t3c_fail", fc1, 4);

    // MODE=0 issues and bubbles; COUT noise on an expected-ERR INC_B
    clear();
    op(1, 0, 4'h0, 2'b11, 8'd1, 8'd2, 0, 16'hBEEF, 6'h3F, 0);
    op(0, 1, 4'h0, 2'b11, 8'd1, 8'd2, 0, 16'hBEEF, 6'h3F, 0);
    op(1, 0, 4'h4, 2'b01, 8'd3, 8'd2, 0, 16'hBEEF, 6'h3F, 0);
    op(1, 1, 4'h6, 2'b01, 8'd0, 8'd3, 0, 16'd0, 6'b101000, 0);
    op(1, 0, 4'h9, 2'b11, 8'd7, 8'd7, 0, 16'hBEEF, 6'h3F, 0);
    op(0, 0, 4'h0, 2'b00, 8'd0, 8'd0, 0, 16'hBEEF, 6'h3F, 0);
    op(1, 1, 4'h6, 2'b01, 8'd0, 8'd3, 0, 16'd0, 6'b100000, 0);
    op(1, 0, 4'h1, 2'b11, 8'd7, 8'd7, 0, 16'hBEEF, 6'h3F, 0);
    idle(3);
    chk("t4_skip", sc1, 4); chk("t4_pass", pc1, 2); chk("t4_fail", fc1, 0);

    // Saturation of FAIL_CNT, then CLR
    clear();
    for (int i = 0; i < 65540; i++) op(1, 1, 4'h0, 2'b11, 8'd1, 8'd1, 0, 16'd0, 6'b000000, 1);
    idle(3);
    chk("t5_fail_sat", fc1, 16'hFFFF); chk("t5_sticky", st1, 1); chk("t5_pass", pc1, 0);
    clear();
    chk("t5_clr_pass", pc1, 0); chk("t5_clr_fail", fc1, 0); chk("t5_clr_skip", sc1, 0);
    chk("t5_clr_sticky", st1, 0); chk("t5_clr_fcmd", fcmd1, 0);
    chk("t5_clr_fexp", fexp1, 0); chk("t5_clr_fact", fact1, 0);

    // LATENCY=3: timing of one issue, then async reset with three in flight
    @(negedge clk);
    ce1 = 1'b0; mode = 1'b1; cmd = 4'h4; valid = 2'b01; opa = 8'd7; opb = 8'd0; cin = 1'b0;
    c0 = cyc; ce3 = 1'b1;
    @(negedge clk); ce3 = 1'b0;
    repeat (5) @(negedge clk);
    chk("l3_pulses", n_cv3, 1); chk("l3_cycle", last_cv3, c0 + 4);
    chk("l3_pass", pc3, 1); chk("l3_mis", mis3, 0);
    ce3 = 1'b1;
    repeat (3) @(negedge clk);
    ce3 = 1'b0;
    chk("l3_pre_rst_pass", pc3, 1);
    #2 rst3_n = 1'b0;
    #1;
    chk("l3_rst_pass", pc3, 0); chk("l3_rst_cv", cv3, 0); chk("l3_rst_sticky", st3, 0);
    chk("l3_rst_fail", fc3, 0); chk("l3_rst_fact", fact3, 0);
    @(negedge clk); rst3_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("l3_no_stale_pulse", n_cv3, 1);
    c0 = cyc; ce3 = 1'b1;
    @(negedge clk); ce3 = 1'b0;
    repeat (5) @(negedge clk);
    chk("l3_post_pulses", n_cv3, 2); chk("l3_post_cycle", last_cv3, c0 + 4);
    chk("l3_post_pass", pc3, 1);

    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end
endmodule
